// File: rtl/pid_gain_regfile_if.sv
// rtl/pid_gain_regfile_if.sv - I2C-slave side write/read bus of the PID gain register file
interface pid_gain_regfile_if #(
    parameter int GAIN_W = 6
);
    logic              wr_tgl;
    logic [1:0]        wr_addr;
    logic [GAIN_W-1:0] wr_data;
    logic [1:0]        rd_addr;
    logic [GAIN_W-1:0] read_value;

    modport master (
        output wr_tgl,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  read_value
    );

    modport slave (
        input  wr_tgl,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output read_value
    );
endinterface

// File: rtl/pid_gain_regfile.sv
// rtl/pid_gain_regfile.sv - CDC write capture, shadow/active PID gains with tick-aligned commit
module pid_gain_regfile #(
    parameter int                GAIN_W  = 6,
    parameter logic [GAIN_W-1:0] KP_INIT = '0,
    parameter logic [GAIN_W-1:0] KI_INIT = '0,
    parameter logic [GAIN_W-1:0] KD_INIT = '0,
    parameter int                ERR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pid_gain_regfile_if.slave   bus,
    input  logic                sample_tick,
    input  logic                lock,
    output logic [GAIN_W-1:0]   kp,
    output logic [GAIN_W-1:0]   ki,
    output logic [GAIN_W-1:0]   kd,
    output logic [2:0]          pending,
    output logic                gains_updated,
    output logic [ERR_W-1:0]    err_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q;
    logic              meta_q;
    logic              sync_q;
    logic              prev_q;
    logic [1:0]        prime_cnt_q;
    logic [GAIN_W-1:0] kp_sh_q, ki_sh_q, kd_sh_q;
    logic [GAIN_W-1:0] kp_q, ki_q, kd_q;
    logic [2:0]        pending_q;
    logic              gains_updated_q;
    logic [ERR_W-1:0]  err_count_q;
    logic [GAIN_W-1:0] read_value_q;

    logic              wr_evt;
    logic [2:0]        wr_sel;
    logic              wr_bad;
    logic [GAIN_W-1:0] read_value_d;

    assign wr_evt = sync_q ^ prev_q;

    always_comb begin
        wr_sel = 3'b000;
        wr_bad = 1'b0;
        if (wr_evt) begin
            case (bus.wr_addr)
                2'd0:    wr_sel = 3'b001;
                2'd1:    wr_sel = 3'b010;
                2'd2:    wr_sel = 3'b100;
                default: wr_bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        read_value_d = '0;
        case (bus.rd_addr)
            2'd0:    read_value_d = kp_sh_q;
            2'd1:    read_value_d = ki_sh_q;
            2'd2:    read_value_d = kd_sh_q;
            default: read_value_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            meta_q          <= 1'b0;
            sync_q          <= 1'b0;
            prev_q          <= 1'b0;
            prime_cnt_q     <= 2'd0;
            kp_sh_q         <= KP_INIT;
            ki_sh_q         <= KI_INIT;
            kd_sh_q         <= KD_INIT;
            kp_q            <= KP_INIT;
            ki_q            <= KI_INIT;
            kd_q            <= KD_INIT;
            pending_q       <= 3'b000;
            gains_updated_q <= 1'b0;
            err_count_q     <= '0;
            read_value_q    <= '0;
        end else begin
            meta_q <= bus.wr_tgl;
            sync_q <= meta_q;
            // While the synchronizer refills after reset, prev tracks the value sync is
            // about to take, so a wr_tgl level held through reset is never seen as a toggle.
            if (prime_cnt_q != 2'd2) begin
                prev_q      <= meta_q;
                prime_cnt_q <= prime_cnt_q + 2'd1;
            end else begin
                prev_q <= sync_q;
            end

            if (wr_sel[0]) kp_sh_q <= bus.wr_data;
            if (wr_sel[1]) ki_sh_q <= bus.wr_data;
            if (wr_sel[2]) kd_sh_q <= bus.wr_data;
            if (wr_bad && (err_count_q != {ERR_W{1'b1}})) err_count_q <= err_count_q + 1'b1;

            read_value_q    <= read_value_d;
            gains_updated_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    pending_q <= pending_q | wr_sel;
                    if (pending_q != 3'b000) state_q <= ARMED;
                end
                ARMED: begin
                    pending_q <= pending_q | wr_sel;
                    if (sample_tick && !lock) state_q <= COMMIT;
                end
                COMMIT: begin
                    // Shadow regs still hold start-of-cycle values here; a write landing now stays pending.
                    if (pending_q[0]) kp_q <= kp_sh_q;
                    if (pending_q[1]) ki_q <= ki_sh_q;
                    if (pending_q[2]) kd_q <= kd_sh_q;
                    pending_q       <= wr_sel;
                    gains_updated_q <= 1'b1;
                    state_q         <= (wr_sel != 3'b000) ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.read_value = read_value_q;
    assign kp             = kp_q;
    assign ki             = ki_q;
    assign kd             = kd_q;
    assign pending        = pending_q;
    assign gains_updated  = gains_updated_q;
    assign err_count      = err_count_q;
endmodule
